// File: rtl/mont_pkg.sv
// Shared constants and types for the Montgomery multiplier output path.
// The redundant product has 2*NUM_ELEMENTS+1 limbs. Each limb is BIT_LEN wide,
// and limb i sits at weight 2^(WORD_LEN*i).
package mont_pkg;
  localparam int NUM_ELEMENTS = 17;
  localparam int BIT_LEN      = 17;
  localparam int WORD_LEN     = 16;
  localparam int NUM_LIMBS    = 2*NUM_ELEMENTS+1;
  localparam int CARRY_W      = BIT_LEN-WORD_LEN+1;
  localparam int IDX_W        = $clog2(NUM_LIMBS);

  typedef logic [BIT_LEN-1:0]  limb_t;
  typedef logic [WORD_LEN-1:0] digit_t;
  typedef logic [CARRY_W-1:0]  carry_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} norm_state_e;
endpackage

// File: rtl/redundant_product_normalizer_limb_carry_step.sv
// One carry-resolution step, purely combinational: limb + carry_in -> canonical
// digit plus carry out. It is reused by the later reduction stage.
module limb_carry_step #(
  parameter int BIT_LEN  = 17,
  parameter int WORD_LEN = 16,
  localparam int CARRY_W = BIT_LEN-WORD_LEN+1,
  localparam int SUM_W   = BIT_LEN+1
) (
  input  logic [BIT_LEN-1:0]  limb_i,
  input  logic [CARRY_W-1:0]  carry_i,
  output logic [WORD_LEN-1:0] digit_o,
  output logic [CARRY_W-1:0]  carry_o
);
  logic [SUM_W-1:0] sum;

  // The sum is one bit wider than a limb. Its upper bits become the next carry.
  assign sum     = {1'b0, limb_i} + SUM_W'(carry_i);
  assign digit_o = sum[WORD_LEN-1:0];
  assign carry_o = sum[SUM_W-1:WORD_LEN];
endmodule

// File: rtl/redundant_product_normalizer.sv
// redundant_product_normalizer: this block turns the redundant-form multiplier
// product into a packed canonical binary product. It resolves one limb per
// cycle and hands the result downstream over a valid/ready handshake.
// Optional feature macro: NORM_OVERFLOW_CHECK_EN. When it is defined, a nonzero
// final carry raises out_overflow. When it is undefined, out_overflow stays 0.
module redundant_product_normalizer
  import mont_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [BIT_LEN-1:0]            in_limbs [NUM_LIMBS],
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_LEN*NUM_LIMBS-1:0] out_result,
  output logic                          out_overflow,
  output logic                          busy
);
`ifdef NORM_OVERFLOW_CHECK_EN
  localparam logic OVF_EN = 1'b1;
`else
  // The final-carry compare stays in place. Only the flag is masked.
  localparam logic OVF_EN = 1'b0;
`endif

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS-1);

  norm_state_e                   state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  carry_t                        carry_q, carry_d;
  limb_t                         limbs_q [NUM_LIMBS];
  limb_t                         limbs_d [NUM_LIMBS];
  logic [WORD_LEN*NUM_LIMBS-1:0] result_q, result_d;
  logic                          in_ready_q, in_ready_d;
  logic                          out_valid_q, out_valid_d;
  logic                          busy_q, busy_d;
  logic                          overflow_q, overflow_d;

  digit_t step_digit;
  carry_t step_carry;

  limb_carry_step #(.BIT_LEN(BIT_LEN), .WORD_LEN(WORD_LEN)) u_step (
    .limb_i  (limbs_q[idx_q]),
    .carry_i (carry_q),
    .digit_o (step_digit),
    .carry_o (step_carry)
  );

  // Next-state logic: accept in IDLE, resolve one limb per RUN cycle, hold in DONE.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    limbs_d    = limbs_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          limbs_d    = in_limbs;
          idx_d      = '0;
          carry_d    = '0;
          result_d   = '0;
          overflow_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        result_d[idx_q*WORD_LEN +: WORD_LEN] = step_digit;
        carry_d = step_carry;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          overflow_d = OVF_EN & (step_carry != '0);
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are decoded from the next state, so they are registered.
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == RUN);
    out_valid_d = (state_d == DONE);
  end

  // All FSM state, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= '0;
      limbs_q     <= '{default: '0};
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      limbs_q     <= limbs_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign out_result   = result_q;
  assign out_overflow = overflow_q;
endmodule

// File: tb/tb_redundant_product_normalizer.sv
// Directed + random bench for redundant_product_normalizer. Expected results
// come from hand constants and from a wide-integer sum of limb[i]*2^(16i).
module tb_redundant_product_normalizer;
  localparam int NL = 35;
  localparam int BL = 17;
  localparam int WL = 16;
  localparam int RW = WL*NL;

`ifdef NORM_OVERFLOW_CHECK_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [BL-1:0] in_limbs [NL];
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_result;
  logic          out_overflow;
  logic          busy;

  redundant_product_normalizer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_limbs     (in_limbs),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  logic [BL-1:0] stim [NL];
  logic [575:0]  exp_sum;
  logic [RW-1:0] last_res;
  logic          last_ovf;
  logic [RW-1:0] hand;
  logic [575:0]  exp_b;

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: plain integer sum of the limbs at their weights.
  function automatic logic [575:0] model_sum();
    logic [575:0] acc = '0;
    for (int i = 0; i < NL; i++) acc = acc + ({559'd0, stim[i]} << (16*i));
    return acc;
  endfunction

  function automatic logic model_ovf(input logic [575:0] s);
    return OVF_ON & (s[575:RW] != '0);
  endfunction

  // Waits for out_valid after the accepting edge, bounded, and checks latency.
  task automatic wait_out();
    int n = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin n = k; break; end
    end
    chk("latency", 576'(n), 576'(35));
  endtask

  // Checks the held result, then completes the output handshake.
  task automatic finish_product(input logic [575:0] s);
    last_res = out_result;
    last_ovf = out_overflow;
    chk("result", {16'd0, out_result}, {16'd0, s[RW-1:0]});
    chk("overflow", 576'(out_overflow), 576'(model_ovf(s)));
    chk("done_in_ready", 576'(in_ready), 576'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_hs_valid", 576'(out_valid), 576'(0));
  endtask

  // Sends stim, then scrambles in_limbs during RUN to show it is ignored.
  task automatic run_product();
    exp_sum  = model_sum();
    in_limbs = stim;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < NL; i++) in_limbs[i] = BL'($urandom);
    wait_out();
    finish_product(exp_sum);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NL; i++) in_limbs[i] = '0;
    #12;
    chk("rst_in_ready", 576'(in_ready), 576'(1));
    chk("rst_out_valid", 576'(out_valid), 576'(0));
    chk("rst_busy", 576'(busy), 576'(0));
    chk("rst_ovf", 576'(out_overflow), 576'(0));
    chk("rst_result", {16'd0, out_result}, 576'(0));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // All-zero product.
    for (int i = 0; i < NL; i++) stim[i] = '0;
    run_product();
    chk("zero_hand", {16'd0, last_res}, 576'(0));

    // limb0 = 0x1FFFF only.
    stim[0] = 17'h1FFFF;
    run_product();
    chk("l0_hand", {16'd0, last_res}, 576'h1FFFF);
    chk("l0_ovf", 576'(last_ovf), 576'(0));

    // All limbs 0x1FFFF: the final carry is 2.
    for (int i = 0; i < NL; i++) stim[i] = 17'h1FFFF;
    run_product();
    hand = '0;
    hand[15:0] = 16'hFFFF;
    for (int i = 2; i < NL; i++) hand[16*i +: 16] = 16'h0001;
    chk("max_hand", {16'd0, last_res}, {16'd0, hand});
    chk("max_ovf", 576'(last_ovf), 576'(OVF_ON));

    // Backpressure, with a second product offered while DONE.
    for (int i = 0; i < NL-1; i++) stim[i] = BL'($urandom);
    stim[NL-1] = BL'($urandom_range(0, 'h3FFF));
    exp_sum  = model_sum();
    in_limbs = stim;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out();
    for (int i = 0; i < NL; i++) stim[i] = BL'($urandom_range(0, 'hFFFF));
    exp_b    = model_sum();
    in_limbs = stim;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_stable", {16'd0, out_result}, {16'd0, exp_sum[RW-1:0]});
      chk("bp_in_ready", 576'(in_ready), 576'(0));
      chk("bp_valid", 576'(out_valid), 576'(1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_busy", 576'(busy), 576'(0));
    chk("bp_idle_ready", 576'(in_ready), 576'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_accept_busy", 576'(busy), 576'(1));
    wait_out();
    finish_product(exp_b);

    // Reset asserted mid-RUN, at idx 10.
    for (int i = 0; i < NL; i++) stim[i] = 17'h1ABCD;
    in_limbs = stim;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("mid_rst_busy", 576'(busy), 576'(0));
    chk("mid_rst_ready", 576'(in_ready), 576'(1));
    chk("mid_rst_result", {16'd0, out_result}, 576'(0));
    @(negedge clk); rst_n = 1'b1;
    begin
      logic seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; seen |= out_valid; end
      chk("mid_rst_no_valid", 576'(seen), 576'(0));
    end
    chk("mid_rst_ready_after", 576'(in_ready), 576'(1));

    // Random products that fit within 560 bits.
    for (int p = 0; p < 1000; p++) begin
      for (int i = 0; i < NL-1; i++) stim[i] = BL'($urandom_range(0, 'h1FFFF));
      stim[NL-1] = BL'($urandom_range(0, 'h3FFF));
      run_product();
      chk("rand_ovf_zero", 576'(last_ovf), 576'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/redundant_product_normalizer.md
Name: redundant_product_normalizer

Overview:
- Consumer at the output end of the 256-bit limb multiplier.
- Accepts the redundant-form product: NUM_LIMBS = 2*NUM_ELEMENTS+1 limbs, each BIT_LEN wide, limb i at weight 2^(WORD_LEN*i).
- Resolves carries serially, one limb per cycle.
- Returns the canonical packed binary product to the Montgomery ladder datapath over a valid/ready handshake.

Parameters:
- NUM_ELEMENTS, 17, limbs per multiplier operand.
- BIT_LEN, 17, width of each redundant input limb.
- WORD_LEN, 16, canonical digit width (limb weight step).

Ports:
- clk  input  1  sole clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  redundant product present on in_limbs.
- in_ready  output  1  block can accept a product.
- in_limbs  input  BIT_LEN x NUM_LIMBS (unpacked array)  redundant product limbs.
- out_valid  output  1  out_result holds a normalized product.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WORD_LEN*NUM_LIMBS  canonical product, digit i in bits [16i+15:16i].
- out_overflow  output  1  final carry out of the top digit was nonzero.
- busy  output  1  state is RUN.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - in_ready=1, out_valid=0, busy=0, out_overflow=0.
  - out_result all zero; limb registers, carry and index all zero.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch all in_limbs, set idx=0, carry=0, clear out_result, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each edge: s = limb[idx] + carry (BIT_LEN+1 bits); digit[idx] <= s[WORD_LEN-1:0]; carry <= s >> WORD_LEN; idx++.
  - carry register width = BIT_LEN-WORD_LEN+1 (2 bits at defaults). Max carry is 2, so the register never saturates.
  - On the edge that processes idx = NUM_LIMBS-1: go to DONE, assert out_valid, set out_overflow = (final carry != 0).
- Latency: out_valid rises exactly NUM_LIMBS edges after the accepting edge (35 at defaults).
- DONE:
  - out_valid=1; out_result and out_overflow held stable while out_ready=0.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
  - in_ready stays 0 in DONE, so input handoff is never simultaneous with output handoff.
- in_limbs is ignored outside the accepting edge. Changes on in_limbs during RUN do not affect the result.
- Reset asserted mid-RUN or mid-DONE: immediate return to reset values. The in-flight result is discarded and no out_valid pulse occurs.
- in_valid held high through DONE: the next product is accepted only on the first IDLE edge.
- Valid multiplier products fit in 546 bits, so out_overflow=1 indicates a corrupted or out-of-range input.

Optional Feature:
- Macro: NORM_OVERFLOW_CHECK_EN.
- Defined: out_overflow computed as above.
- Undefined:
  - out_overflow tied to 0.
  - Final carry discarded.
  - Carry register and compare logic still present; only the output flag is removed.

Decomposition:
- Shared package `mont_pkg` holds:
  - NUM_ELEMENTS, BIT_LEN, WORD_LEN, NUM_LIMBS.
  - CARRY_W = BIT_LEN-WORD_LEN+1.
  - typedef limb_t (BIT_LEN), digit_t (WORD_LEN).
  - enum norm_state_e {IDLE, RUN, DONE}.
- One natural sub-module, `limb_carry_step`: combinational limb+carry → digit, next carry. Reusable by the later reduction stage.
- FSM, index counter and result register stay in the top module.

Test Plan:
- All limbs 0 accepted → out_valid after exactly 35 edges; out_result=0; out_overflow=0.
- limb[0]=0x1FFFF, rest 0 → digit0=0xFFFF, digit1=0x0001, all other digits 0; overflow 0.
- All 35 limbs=0x1FFFF → digit0=0xFFFF, digit1=0x0000, digits 2..34=0x0001; final carry 2, so out_overflow=1 with the macro defined and 0 without it.
- Backpressure:
  - Stimulus: random product; out_ready held low 5 cycles after out_valid; new in_valid offered meanwhile.
  - Response: out_result stable; in_ready=0; second product accepted only on the edge after the out_ready handshake.
- Reset mid-operation:
  - Stimulus: rst_n low during RUN at idx=10.
  - Response: all outputs return to reset values asynchronously; no out_valid; in_ready=1 after release.
- Random regression, 1000 products from reference A*B limb vectors → out_result equals the integer sum of limb[i]*2^(16i); overflow always 0.
